// File: rtl/seg7_seq_monitor.sv
// rtl/seg7_seq_monitor.sv - seven-segment sequence tracker with direction detect and error count
module seg7_seq_monitor #(
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             E,
    input  logic             F,
    input  logic             G,
    output logic [3:0]       digit,
    output logic [3:0]       pos,
    output logic             locked,
    output logic             modo_det,
    output logic             erro,
    output logic             dir_change,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        FIRST   = 2'd1,
        TRACK   = 2'd2
    } state_t;

    localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    // Pattern order is A (MSB) down to G (LSB); result is {valid, value}.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1111110: r = {1'b1, 4'h0};
            7'b0110000: r = {1'b1, 4'h1};
            7'b1101101: r = {1'b1, 4'h2};
            7'b1111001: r = {1'b1, 4'h3};
            7'b0110011: r = {1'b1, 4'h4};
            7'b1011011: r = {1'b1, 4'h5};
            7'b1011111: r = {1'b1, 4'h6};
            7'b1110000: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1111011: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b0011111: r = {1'b1, 4'hB};
            7'b1001110: r = {1'b1, 4'hC};
            7'b0111101: r = {1'b1, 4'hD};
            7'b1001111: r = {1'b1, 4'hE};
            7'b1000111: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    // Digit stored at each position of the tracked sequence.
    function automatic logic [3:0] seq_at(input logic [3:0] idx);
        logic [3:0] v;
        case (idx)
            4'd0:    v = 4'h2;
            4'd1:    v = 4'h5;
            4'd2:    v = 4'h7;
            4'd3:    v = 4'h3;
            4'd4:    v = 4'hA;
            4'd5:    v = 4'hE;
            4'd6:    v = 4'h8;
            4'd7:    v = 4'h0;
            4'd8:    v = 4'hB;
            4'd9:    v = 4'h4;
            4'd10:   v = 4'h6;
            4'd11:   v = 4'hD;
            4'd12:   v = 4'hF;
            4'd13:   v = 4'h1;
            4'd14:   v = 4'hC;
            default: v = 4'h9;
        endcase
        return v;
    endfunction

    // Inverse of seq_at: position of a digit in the sequence.
    function automatic logic [3:0] seq_index(input logic [3:0] val);
        logic [3:0] i;
        case (val)
            4'h0:    i = 4'd7;
            4'h1:    i = 4'd13;
            4'h2:    i = 4'd0;
            4'h3:    i = 4'd3;
            4'h4:    i = 4'd9;
            4'h5:    i = 4'd1;
            4'h6:    i = 4'd10;
            4'h7:    i = 4'd2;
            4'h8:    i = 4'd6;
            4'h9:    i = 4'd15;
            4'hA:    i = 4'd4;
            4'hB:    i = 4'd8;
            4'hC:    i = 4'd14;
            4'hD:    i = 4'd11;
            4'hE:    i = 4'd5;
            default: i = 4'd12;
        endcase
        return i;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       digit_nxt;
    logic [3:0]       pos_nxt;
    logic             modo_nxt;
    logic             erro_nxt;
    logic             dchg_nxt;
    logic [ERR_W-1:0] cnt_nxt;

    logic [4:0]       dec;
    logic             samp_valid;
    logic [3:0]       samp_val;
    logic [3:0]       samp_pos;
    logic [3:0]       fwd_val;
    logic [3:0]       bwd_val;
    logic [3:0]       want_val;
    logic [3:0]       opp_val;

    assign dec        = seg_decode({A, B, C, D, E, F, G});
    assign samp_valid = dec[4];
    assign samp_val   = dec[3:0];
    assign samp_pos   = seq_index(samp_val);
    // 4-bit position arithmetic wraps 15<->0 by itself.
    assign fwd_val    = seq_at(pos + 4'd1);
    assign bwd_val    = seq_at(pos - 4'd1);
    assign want_val   = modo_det ? bwd_val : fwd_val;
    assign opp_val    = modo_det ? fwd_val : bwd_val;

    // State register and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ACQUIRE;
            digit      <= 4'd0;
            pos        <= 4'd0;
            locked     <= 1'b0;
            modo_det   <= 1'b0;
            erro       <= 1'b0;
            dir_change <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            digit      <= digit_nxt;
            pos        <= pos_nxt;
            locked     <= (state_nxt == TRACK);
            modo_det   <= modo_nxt;
            erro       <= erro_nxt;
            dir_change <= dchg_nxt;
            err_count  <= cnt_nxt;
        end
    end

    // Next-state and next-output decision for one sampled pattern.
    always_comb begin
        state_nxt = state;
        digit_nxt = digit;
        pos_nxt   = pos;
        modo_nxt  = modo_det;
        erro_nxt  = 1'b0;
        dchg_nxt  = 1'b0;
        cnt_nxt   = err_count;
        if (en) begin
            case (state)
                ACQUIRE: begin
                    if (samp_valid) begin
                        digit_nxt = samp_val;
                        pos_nxt   = samp_pos;
                        state_nxt = FIRST;
                    end
                end
                FIRST: begin
                    if (!samp_valid) begin
                        state_nxt = ACQUIRE;
                    end else if (samp_val == fwd_val) begin
                        digit_nxt = samp_val;
                        pos_nxt   = samp_pos;
                        modo_nxt  = 1'b0;
                        state_nxt = TRACK;
                    end else if (samp_val == bwd_val) begin
                        digit_nxt = samp_val;
                        pos_nxt   = samp_pos;
                        modo_nxt  = 1'b1;
                        state_nxt = TRACK;
                    end else if (samp_val != digit) begin
                        digit_nxt = samp_val;
                        pos_nxt   = samp_pos;
                    end
                end
                TRACK: begin
                    if (samp_valid && samp_val == want_val) begin
                        digit_nxt = samp_val;
                        pos_nxt   = samp_pos;
                    end else if (samp_valid && samp_val == opp_val) begin
                        digit_nxt = samp_val;
                        pos_nxt   = samp_pos;
                        modo_nxt  = ~modo_det;
                        dchg_nxt  = 1'b1;
                    end else if (samp_valid && samp_val == digit) begin
                        // stall: hold everything
                    end else begin
                        erro_nxt = 1'b1;
                        if (err_count != CNT_MAX) begin
                            cnt_nxt = err_count + CNT_ONE;
                        end
                        if (samp_valid) begin
                            digit_nxt = samp_val;
                            pos_nxt   = samp_pos;
                            state_nxt = FIRST;
                        end else begin
                            state_nxt = ACQUIRE;
                        end
                    end
                end
                default: state_nxt = ACQUIRE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_seq_monitor.sv
// tb/tb_seg7_seq_monitor.sv - randomized and directed bench for seg7_seq_monitor
module tb_seg7_seq_monitor;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0, E = 1'b0, F = 1'b0, G = 1'b0;

    logic [3:0] digit, pos;
    logic       locked, modo_det, erro, dir_change;
    logic [7:0] err_count;

    logic [3:0] digit2, pos2;
    logic       locked2, modo2, erro2, dchg2;
    logic [1:0] err_count2;

    int errors = 0;
    int checks = 0;

    seg7_seq_monitor #(.ERR_W(8)) dut (
        .clock(clock), .reset(reset), .en(en),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
        .digit(digit), .pos(pos), .locked(locked), .modo_det(modo_det),
        .erro(erro), .dir_change(dir_change), .err_count(err_count)
    );

    seg7_seq_monitor #(.ERR_W(2)) dut2 (
        .clock(clock), .reset(reset), .en(en),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
        .digit(digit2), .pos(pos2), .locked(locked2), .modo_det(modo2),
        .erro(erro2), .dir_change(dchg2), .err_count(err_count2)
    );

    always #5 clock = ~clock;

    logic [6:0] code [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    int seq [16] = '{2, 5, 7, 3, 10, 14, 8, 0, 11, 4, 6, 13, 15, 1, 12, 9};

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (code[i] == p) return i;
        return -1;
    endfunction

    function automatic int where(input int v);
        for (int i = 0; i < 16; i++) if (seq[i] == v) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = hunting, 1 = one digit seen, 2 = following the sequence.
    int m_mode = 0, m_digit = 0, m_pos = 0, m_dir = 0, m_erro = 0, m_dchg = 0, m_cnt = 0, m_cnt2 = 0;

    always @(posedge clock or negedge reset) begin
        int v, fwd, bwd, want, opp;
        if (!reset) begin
            m_mode = 0; m_digit = 0; m_pos = 0; m_dir = 0;
            m_erro = 0; m_dchg = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_erro = 0;
            m_dchg = 0;
            if (en) begin
                v    = decode({A, B, C, D, E, F, G});
                fwd  = seq[(m_pos + 1) % 16];
                bwd  = seq[(m_pos + 15) % 16];
                want = m_dir ? bwd : fwd;
                opp  = m_dir ? fwd : bwd;
                if (m_mode == 0) begin
                    if (v >= 0) begin m_digit = v; m_pos = where(v); m_mode = 1; end
                end else if (m_mode == 1) begin
                    if (v < 0) m_mode = 0;
                    else if (v == fwd) begin m_digit = v; m_pos = where(v); m_dir = 0; m_mode = 2; end
                    else if (v == bwd) begin m_digit = v; m_pos = where(v); m_dir = 1; m_mode = 2; end
                    else if (v != m_digit) begin m_digit = v; m_pos = where(v); end
                end else begin
                    if (v >= 0 && v == want) begin m_digit = v; m_pos = where(v); end
                    else if (v >= 0 && v == opp) begin
                        m_digit = v; m_pos = where(v); m_dir = 1 - m_dir; m_dchg = 1;
                    end else if (v >= 0 && v == m_digit) begin
                    end else begin
                        m_erro = 1;
                        if (m_cnt < 255) m_cnt++;
                        if (m_cnt2 < 3) m_cnt2++;
                        if (v < 0) m_mode = 0;
                        else begin m_digit = v; m_pos = where(v); m_mode = 1; end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (reset) begin
            chk("digit", digit, m_digit);
            chk("pos", pos, m_pos);
            chk("locked", locked, (m_mode == 2) ? 1 : 0);
            chk("modo_det", modo_det, m_dir);
            chk("erro", erro, m_erro);
            chk("dir_change", dir_change, m_dchg);
            chk("err_count", err_count, m_cnt);
            chk("err_count_w2", err_count2, m_cnt2);
            chk("pulse_exclusive", (erro && dir_change) ? 1 : 0, 0);
        end
    end

    task automatic step(input logic e, input logic [6:0] p);
        en = e;
        {A, B, C, D, E, F, G} = p;
        @(posedge clock);
        #1;
    endtask

    task automatic sd(input int d);
        step(1'b1, code[d]);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        chk("rst_locked", locked, 0);
        chk("rst_digit", digit, 0);
        chk("rst_pos", pos, 0);
        chk("rst_modo", modo_det, 0);
        chk("rst_erro", erro, 0);
        chk("rst_dchg", dir_change, 0);
        chk("rst_count", err_count, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    int w_idx = 0;
    int w_dir = 0;

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("init_digit", digit, 0);
        chk("init_locked", locked, 0);
        chk("init_count", err_count, 0);
        reset = 1'b1;

        // forward run 2,5,7,3
        sd(2);
        chk("fwd1_locked", locked, 0);
        chk("fwd1_digit", digit, 2);
        sd(5);
        chk("fwd2_locked", locked, 1);
        chk("fwd2_modo", modo_det, 0);
        sd(7);
        sd(3);
        chk("fwd4_digit", digit, 3);
        chk("fwd4_pos", pos, 3);
        chk("fwd4_count", err_count, 0);
        chk("model_pos", m_pos, 3);

        // reversal 2,5,7,5
        pulse_reset();
        sd(2); sd(5); sd(7); sd(5);
        chk("rev_dchg", dir_change, 1);
        chk("rev_modo", modo_det, 1);
        chk("rev_digit", digit, 5);
        chk("rev_erro", erro, 0);
        step(1'b0, code[8]);
        chk("rev_dchg_clear", dir_change, 0);

        // wrap forward 9 -> 2, then backward 2 -> 9
        pulse_reset();
        sd(1); sd(12); sd(9);
        chk("wrap_pre_pos", pos, 15);
        sd(2);
        chk("wrap_fwd_pos", pos, 0);
        chk("wrap_fwd_erro", erro, 0);
        sd(9);
        chk("wrap_bwd_pos", pos, 15);
        chk("wrap_bwd_erro", erro, 0);

        // mismatch while locked at A
        pulse_reset();
        sd(3); sd(10);
        chk("mm_locked_pre", locked, 1);
        chk("mm_pos_pre", pos, 4);
        sd(1);
        chk("mm_erro", erro, 1);
        chk("mm_count", err_count, 1);
        chk("mm_locked", locked, 0);
        chk("mm_digit", digit, 1);
        chk("mm_pos", pos, 13);
        step(1'b1, 7'b0000000);
        chk("mm_inv_erro", erro, 0);
        chk("mm_inv_digit_hold", digit, 1);
        chk("model_mode_acq", m_mode, 0);

        // strobe and stall
        pulse_reset();
        sd(2); sd(5);
        step(1'b0, code[7]);
        step(1'b0, code[8]);
        chk("strobe_digit", digit, 5);
        chk("strobe_locked", locked, 1);
        sd(5);
        chk("stall_erro", erro, 0);
        chk("stall_digit", digit, 5);

        // saturation of the narrow counter: five mismatches
        pulse_reset();
        sd(2); sd(5); sd(0); sd(11); sd(2); sd(5); sd(0); sd(11); sd(2); sd(5); sd(0);
        chk("sat_count8", err_count, 5);
        chk("sat_count2", err_count2, 3);
        chk("model_cnt2", m_cnt2, 3);

        // reset mid-track drops outputs without a clock edge
        pulse_reset();
        sd(2); sd(5); sd(7);
        pulse_reset();

        // randomized walk with stalls, reversals, jumps, garbage and strobe gaps
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (i % 900 == 450) pulse_reset();
            if (r < 8) begin
                step(1'b0, 7'($urandom));
            end else if (r < 55) begin
                w_idx = (w_idx + (w_dir ? 15 : 1)) % 16;
                sd(seq[w_idx]);
            end else if (r < 63) begin
                w_dir = 1 - w_dir;
                w_idx = (w_idx + (w_dir ? 15 : 1)) % 16;
                sd(seq[w_idx]);
            end else if (r < 73) begin
                sd(seq[w_idx]);
            end else if (r < 90) begin
                w_idx = $urandom_range(0, 15);
                sd(seq[w_idx]);
            end else begin
                step(1'b1, 7'($urandom));
            end
        end

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_seq_monitor.md
SEG7_SEQ_MONITOR -- requirements
Module: seg7_seq_monitor

Interface
REQ-001 SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-002 SHALL have port clock, input, 1, the single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port en, input, 1, sample strobe; segments are sampled only on edges with en=1.
REQ-005 SHALL have ports A, B, C, D, E, F, G, input, 1 each, active-high 7-segment pattern under observation.
REQ-006 SHALL have port digit, output, 4, hex value decoded from the last valid sample.
REQ-007 SHALL have port pos, output, 4, index of digit in the sequence table (REQ-010).
REQ-008 SHALL have port locked, output, 1, high while the sequence is tracked; modo_det, output, 1, tracked direction (0 forward, 1 backward); erro, output, 1, one-cycle mismatch pulse; dir_change, output, 1, one-cycle direction-reversal pulse; err_count, output, ERR_W, saturating mismatch count.

Function
REQ-009 SHALL decode ABCDEFG as: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, B=0011111, C=1001110, D=0111101, E=1001111, F=1000111; any other pattern is invalid.
REQ-010 SHALL use the sequence table, index 0..15: 2,5,7,3,A,E,8,0,B,4,6,D,F,1,C,9; forward successor of index 15 is 0, backward successor of index 0 is 15.
REQ-011 SHALL implement states ACQUIRE, FIRST, TRACK; samples with en=0 cause no state or output change except erro/dir_change clearing.
REQ-012 ACQUIRE: valid sample -> load digit/pos, go FIRST; invalid sample -> stay ACQUIRE.
REQ-013 FIRST: sample equal to forward successor of pos -> TRACK, modo_det=0; equal to backward successor -> TRACK, modo_det=1; equal to current digit -> stay FIRST; other valid -> reload digit/pos, stay FIRST; invalid -> ACQUIRE; no error reported in FIRST.
REQ-014 TRACK: sample equal to successor in direction modo_det -> update digit/pos, stay TRACK.
REQ-015 TRACK: sample equal to successor in opposite direction -> toggle modo_det, pulse dir_change, update digit/pos, no error.
REQ-016 TRACK: sample equal to current digit (stall) -> no change, no error.
REQ-017 TRACK: any other sample -> pulse erro, increment err_count; valid sample -> reload digit/pos, go FIRST; invalid -> ACQUIRE.
REQ-018 err_count SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-019 locked SHALL be 1 exactly in TRACK; all outputs registered, reflecting a sample one edge after the sampling edge.
REQ-020 erro and dir_change SHALL be high for exactly one cycle after the triggering edge, never simultaneously.
REQ-021 digit and pos SHALL hold their last values while in ACQUIRE.

Reset
REQ-022 reset=0 SHALL immediately force state ACQUIRE, digit=0, pos=0, locked=0, modo_det=0, erro=0, dir_change=0, err_count=0, independent of clock.
REQ-023 reset asserted mid-TRACK SHALL discard lock and count; after release the block reacquires from ACQUIRE.
REQ-024 Reset release SHALL be synchronised by the integrator; the block needs no internal handling beyond REQ-022.

Verification
REQ-025 Forward run: en=1, patterns 2,5,7,3 on successive edges -> locked=1 after 2nd edge, modo_det=0, digit=3, pos=3, err_count=0.
REQ-026 Wrap: forward from 9 (pos 15) to 2 -> pos=0, no erro; backward from 2 to 9 -> pos=15, no erro.
REQ-027 Reversal: forward 2,5,7 then 5 -> dir_change pulse one cycle, modo_det=1, digit=5, erro=0.
REQ-028 Mismatch: locked at A (pos 4), sample 1 -> erro one cycle, err_count=1, locked=0, digit=1, pos=13; invalid pattern 0000000 -> ACQUIRE.
REQ-029 Saturation: ERR_W=2, five mismatches -> err_count=3 stays 3.
REQ-030 Stall/strobe: en=0 with changing segments -> no change; repeated same digit in TRACK -> no erro; reset low mid-TRACK -> all outputs 0 without clock edge.
